clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   Multi-channel programmable clock divider / tick generator for the sim CPU
//   platform. Each channel derives a divided clock-enable waveform and a wrap
//   strobe from clk. Divisor and high time are runtime-configurable through a
//   valid/ready port and applied glitch-free at the period boundary.
// PARAMETERS
//   CHANNELS  4           number of independent divider channels (>=1)
//   CNT_W     26          width of counter, divisor and high-time registers
//   DEF_DIV   50_000_000  reset divisor of every channel (2..2^CNT_W-1)
//   DEF_HIGH  DEF_DIV/2   reset high time of every channel (1..DEF_DIV-1)
// PORTS
//   clk        in   1         system clock
//   rst_n      in   1         reset; synchronous, active-low
//   en         in   CHANNELS  per-channel run enable
//   cfg_valid  in   1         config request valid
//   cfg_ready  out  1         config request accepted this cycle if valid
//   cfg_ch     in   CH_W      target channel; CH_W = max(1,$clog2(CHANNELS))
//   cfg_div    in   CNT_W     new divisor (period in clk cycles)
//   cfg_high   in   CNT_W     new high time in clk cycles
//   cfg_err    out  1         one-cycle pulse: last accepted request rejected
//   clk_out    out  CHANNELS  divided waveform, registered
//   tick       out  CHANNELS  one-cycle strobe per period, registered
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): cnt=0, div=DEF_DIV, high=DEF_HIGH, pending=0,
//     clk_out=0, tick=0, cfg_err=0; any queued shadow config is discarded.
//   Per channel i, each posedge with en[i]=1:
//     cnt <= (cnt >= div-1) ? 0 : cnt+1
//     clk_out[i] <= (cnt < high); tick[i] <= (cnt == div-1)
//     -> one-cycle latency from cnt; clk_out high exactly `high` of `div` cycles.
//   en[i]=0: cnt <= 0, clk_out[i] <= 0, tick[i] <= 0. Re-enable restarts phase
//     at cnt=0, so clk_out rises on the first enabled edge.
//   Config handshake:
//     cfg_ready = !pending[cfg_ch] (combinational); transfer = valid & ready.
//     Out-of-range cfg_ch (>=CHANNELS) reads as not pending; the request is
//     accepted, then rejected.
//     Legal request: cfg_ch < CHANNELS, cfg_div >= 2, 1 <= cfg_high < cfg_div.
//     Illegal request: consumed, nothing stored, cfg_err=1 on the next cycle.
//     Legal request: shadow regs <= cfg_div/cfg_high, pending <= 1.
//   Apply: at the edge where the channel wraps (en=1 and cnt==div-1), or at
//     any edge with en=0: div/high <= shadow, pending <= 0, cnt <= 0.
//     The current period always completes with the old values, so there are
//     no runt pulses. cfg_ready for that channel is high again next cycle.
//   Simultaneous events: a transfer and an apply on the same channel in one
//     cycle cannot occur (ready requires !pending). Transfers to other
//     channels are independent of any apply.
//   Counter never exceeds div-1; cnt >= div-1 also wraps defensively.
//   Elaboration fails if the DEF_DIV/DEF_HIGH limits above are violated.
// STRUCTURE
//   Package clk_div_pkg: CNT_W default, function cfg_legal(div, high),
//     localparam helper for CH_W.
//   Sub-module clk_div_chan: one channel (counter, active and shadow regs,
//     pending flag, clk_out/tick regs). Instantiated CHANNELS times via
//     generate. The top level holds channel decode, cfg_ready mux and the
//     cfg_err register.
// TESTING
//   1. Reset defaults, DEF_DIV=10, DEF_HIGH=5, en=1 -> clk_out 5 hi / 5 lo,
//      tick every 10 cycles, first clk_out=1 one cycle after reset release.
//   2. Set ch1 to div=2, high=1 mid-period -> old period completes, then
//      clk_out toggles every cycle; ch0 is unaffected.
//   3. Two back-to-back writes to ch1 -> second write sees cfg_ready=0 until
//      apply; then it is accepted and takes effect the following period.
//   4. Illegal requests (div=1; high=0; high=div=8; cfg_ch=CHANNELS) ->
//      cfg_err pulses one cycle each, no output change.
//   5. Drop en[2] for 3 cycles mid-period, with a pending config -> clk_out=0,
//      config applied, restart at cnt=0 on re-enable.
//   6. Assert rst_n=0 for one cycle with pending config -> defaults restored,
//      pending cleared, cfg_ready=1.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and helpers for the multi-channel clock
//                divider (default widths, channel-index width, config check).
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int CNT_W_DEF    = 26;
  localparam int CHANNELS_DEF = 4;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A divisor/high-time pair is usable when the period is at least two
  // cycles and the high phase is neither empty nor the whole period.
  function automatic logic cfg_legal(input logic [63:0] div, input logic [63:0] high);
    return (div >= 64'd2) && (high >= 64'd1) && (high < div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi_if
//  Description : Configuration request port of the clock divider: valid/ready
//                handshake carrying channel, divisor and high time, plus the
//                one-cycle reject pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int CH_W  = ch_width(CHANNELS_DEF),
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high,
    output cfg_ready, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/clk_div_multi_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Free-running period counter with active
//                and shadow divisor/high-time registers; a stored shadow config
//                is swapped in only at the period boundary or while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = 50_000_000,
  parameter int DEF_HIGH = DEF_DIV / 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  input  wire logic             wr_en,
  input  wire logic [CNT_W-1:0] wr_div,
  input  wire logic [CNT_W-1:0] wr_high,
  output logic                  pending,
  output logic                  clk_out,
  output logic                  tick
);

  localparam logic [CNT_W-1:0] c_def_div  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] c_def_high = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             w_last;
  logic             w_apply;

  // Next-state: count/wrap, output decode, boundary-aligned config swap.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    high_d    = high_q;
    sdiv_d    = sdiv_q;
    shigh_d   = shigh_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;

    // ">=" rather than "==" so a counter somehow past the end still wraps.
    w_last  = (cnt_q >= (div_q - c_one));
    w_apply = pending_q && (!en || w_last);

    if (en) begin
      cnt_d     = w_last ? '0 : (cnt_q + c_one);
      clk_out_d = (cnt_q < high_q);
      tick_d    = (cnt_q == (div_q - c_one));
    end else begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end

    // The period that just ended used the old values, so no runt pulse.
    if (w_apply) begin
      div_d     = sdiv_q;
      high_d    = shigh_q;
      pending_d = 1'b0;
      cnt_d     = '0;
    end

    // Only accepted while not pending, so never collides with an apply.
    if (wr_en) begin
      sdiv_d    = wr_div;
      shigh_d   = wr_high;
      pending_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= c_def_div;
      high_q    <= c_def_high;
      sdiv_q    <= c_def_div;
      shigh_q   <= c_def_high;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sdiv_q    <= sdiv_d;
      shigh_q   <= shigh_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pending_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : Multi-channel programmable clock divider / tick generator.
//                Holds the config decode, the ready mux and the reject flag;
//                per-channel counting lives in clk_div_chan.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = 50_000_000,
  parameter int DEF_HIGH = DEF_DIV / 2
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic [CHANNELS-1:0] en,
  clk_div_multi_if.slave           cfg,
  output logic      [CHANNELS-1:0] clk_out,
  output logic      [CHANNELS-1:0] tick
);

  localparam int c_ch_w  = ch_width(CHANNELS);
  localparam int c_pad_w = 1 << c_ch_w;

  // Reject impossible configurations at elaboration time.
  if (CHANNELS < 1) begin : g_chk_channels
    $error("clk_div_multi: CHANNELS must be at least 1");
  end
  if ((DEF_DIV < 2) || (longint'(DEF_DIV) > ((longint'(1) << CNT_W) - 1))) begin : g_chk_def_div
    $error("clk_div_multi: DEF_DIV out of range 2..2^CNT_W-1");
  end
  if ((DEF_HIGH < 1) || (DEF_HIGH >= DEF_DIV)) begin : g_chk_def_high
    $error("clk_div_multi: DEF_HIGH out of range 1..DEF_DIV-1");
  end
  if ($bits(cfg.cfg_ch) != c_ch_w) begin : g_chk_if_width
    $error("clk_div_multi: interface CH_W does not match CHANNELS");
  end

  logic [CHANNELS-1:0] w_pending;
  logic [CHANNELS-1:0] w_wr_en;
  logic [c_pad_w-1:0]  w_pend_pad;
  logic                w_ch_ok;
  logic                w_xfer;
  logic                w_legal;
  logic                cfg_err_q, cfg_err_d;

  // Unused channel codes index zero padding, so they read as not pending
  // and the request is taken and then flagged.
  assign w_pend_pad    = c_pad_w'(w_pending);
  assign cfg.cfg_ready = !w_pend_pad[cfg.cfg_ch];

  // Handshake decode and legality of the presented request.
  always_comb begin
    w_ch_ok   = (int'(cfg.cfg_ch) < CHANNELS);
    w_xfer    = cfg.cfg_valid && cfg.cfg_ready;
    w_legal   = w_ch_ok && cfg_legal(64'(cfg.cfg_div), 64'(cfg.cfg_high));
    cfg_err_d = w_xfer && !w_legal;
  end

  // Reject pulse, visible the cycle after the bad request was consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg.cfg_err = cfg_err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign w_wr_en[i] = w_xfer && w_legal && (cfg.cfg_ch == c_ch_w'(i));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .wr_en   (w_wr_en[i]),
      .wr_div  (cfg.cfg_div),
      .wr_high (cfg.cfg_high),
      .pending (w_pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Directed self-checking bench for clk_div_multi with three
//                channels, 8-bit counters and a 10-cycle default period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

  localparam int CHANNELS = 3;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;

  logic                clk;
  logic                rst_n;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;

  clk_div_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  clk_div_multi #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W),
    .DEF_DIV  (10),
    .DEF_HIGH (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;  // clock edges since the last reset release

  typedef struct {
    string            name;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic             exp_err;
  } ill_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Channel still on the 10/5 reset config, counting since reset release.
  task automatic chk_ref(input int ch);
    int p;
    p = (k - 1) % 10;
    check($sformatf("ch%0d_clk_out k=%0d", ch, k), 32'(clk_out[ch]), 32'(p < 5));
    check($sformatf("ch%0d_tick k=%0d", ch, k), 32'(tick[ch]), 32'(p == 9));
  endtask

  task automatic set_cfg(input logic v, input logic [CH_W-1:0] ch,
                         input logic [CNT_W-1:0] div, input logic [CNT_W-1:0] high);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = div;
    cfg_if.cfg_high  = high;
    #1;
  endtask

  ill_vec_t ill[4];
  int       t3_clk[9];
  int       t3_tick[9];

  initial begin
    ill[0] = '{"div_1",     2'd2, 8'd1, 8'd0, 1'b1};
    ill[1] = '{"high_0",    2'd2, 8'd8, 8'd0, 1'b1};
    ill[2] = '{"high_eq",   2'd2, 8'd8, 8'd8, 1'b1};
    ill[3] = '{"ch_range",  2'd3, 8'd8, 8'd4, 1'b1};
    t3_clk  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    t3_tick = '{0, 0, 1, 0, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    en    = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;

    // ---- reset state ----
    step();
    step();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_if.cfg_err), 32'd0);

    // ---- 1: default 5 high / 5 low, tick every 10 ----
    rst_n = 1'b1;
    en    = '1;
    k     = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      check($sformatf("t1_clk_out k=%0d", k), 32'(clk_out), ((k - 1) % 10 < 5) ? 32'h7 : 32'h0);
      check($sformatf("t1_tick k=%0d", k), 32'(tick), ((k - 1) % 10 == 9) ? 32'h7 : 32'h0);
    end

    // ---- 2: ch1 -> div 2 / high 1 mid-period ----
    repeat (3) begin
      step();
      chk_ref(0);
    end
    set_cfg(1'b1, 2'd1, 8'd2, 8'd1);
    check("t2_ready_before", 32'(cfg_if.cfg_ready), 32'd1);
    step();                               // k=24, transfer
    set_cfg(1'b0, 2'd1, 8'd2, 8'd1);
    check("t2_ready_pending", 32'(cfg_if.cfg_ready), 32'd0);
    check("t2_err", 32'(cfg_if.cfg_err), 32'd0);
    for (int j = 0; j < 12; j++) begin
      step();                             // k=25..36
      chk_ref(0);
      if (k <= 30) begin
        chk_ref(1);
      end else begin
        check($sformatf("t2_ch1_clk k=%0d", k), 32'(clk_out[1]), 32'(k % 2));
        check($sformatf("t2_ch1_tick k=%0d", k), 32'(tick[1]), 32'((k % 2) == 0));
      end
      if (k == 29) check("t2_ready_k29", 32'(cfg_if.cfg_ready), 32'd0);
      if (k == 30) check("t2_ready_k30", 32'(cfg_if.cfg_ready), 32'd1);
    end

    // ---- 3: back-to-back writes to ch1 ----
    set_cfg(1'b1, 2'd1, 8'd4, 8'd1);
    check("t3_ready_w1", 32'(cfg_if.cfg_ready), 32'd1);
    step();                               // k=37, first write taken
    set_cfg(1'b1, 2'd1, 8'd6, 8'd3);
    check("t3_ready_blocked", 32'(cfg_if.cfg_ready), 32'd0);
    step();                               // k=38, first write applied
    check("t3_ready_open", 32'(cfg_if.cfg_ready), 32'd1);
    check("t3_ch1_clk_k38", 32'(clk_out[1]), 32'd0);
    check("t3_ch1_tick_k38", 32'(tick[1]), 32'd1);
    chk_ref(0);
    step();                               // k=39, second write taken
    set_cfg(1'b0, 2'd1, 8'd6, 8'd3);
    check("t3_ready_w2_pend", 32'(cfg_if.cfg_ready), 32'd0);
    check("t3_ch1_clk_k39", 32'(clk_out[1]), 32'd1);
    check("t3_ch1_tick_k39", 32'(tick[1]), 32'd0);
    chk_ref(0);
    for (int j = 0; j < 9; j++) begin
      step();                             // k=40..48
      check($sformatf("t3_ch1_clk k=%0d", k), 32'(clk_out[1]), 32'(t3_clk[j]));
      check($sformatf("t3_ch1_tick k=%0d", k), 32'(tick[1]), 32'(t3_tick[j]));
      chk_ref(0);
      if (k == 41) check("t3_ready_k41", 32'(cfg_if.cfg_ready), 32'd0);
      if (k == 42) check("t3_ready_k42", 32'(cfg_if.cfg_ready), 32'd1);
    end

    // ---- 4: illegal requests ----
    for (int v = 0; v < 4; v++) begin
      set_cfg(1'b1, ill[v].ch, ill[v].div, ill[v].high);
      check({"t4_ready_", ill[v].name}, 32'(cfg_if.cfg_ready), 32'd1);
      step();
      set_cfg(1'b0, 2'd2, 8'd0, 8'd0);
      check({"t4_err_", ill[v].name}, 32'(cfg_if.cfg_err), 32'(ill[v].exp_err));
      chk_ref(0);
      chk_ref(2);
      step();
      check({"t4_err_clr_", ill[v].name}, 32'(cfg_if.cfg_err), 32'd0);
      check({"t4_ch2_ready_", ill[v].name}, 32'(cfg_if.cfg_ready), 32'd1);
      chk_ref(2);
    end

    // ---- 5: drop en[2] with a pending config ----
    set_cfg(1'b1, 2'd2, 8'd4, 8'd2);
    check("t5_ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();                               // k=57, write taken
    set_cfg(1'b0, 2'd2, 8'd4, 8'd2);
    en[2] = 1'b0;
    check("t5_ready_pend", 32'(cfg_if.cfg_ready), 32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("t5_off_clk j=%0d", j), 32'(clk_out[2]), 32'd0);
      check($sformatf("t5_off_tick j=%0d", j), 32'(tick[2]), 32'd0);
      check($sformatf("t5_off_ready j=%0d", j), 32'(cfg_if.cfg_ready), 32'd1);
      chk_ref(0);
    end
    en[2] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      check($sformatf("t5_ch2_clk j=%0d", j), 32'(clk_out[2]), 32'((j - 1) % 4 < 2));
      check($sformatf("t5_ch2_tick j=%0d", j), 32'(tick[2]), 32'((j - 1) % 4 == 3));
      chk_ref(0);
    end

    // ---- 6: reset with a pending config ----
    set_cfg(1'b1, 2'd0, 8'd6, 8'd2);
    check("t6_ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    set_cfg(1'b0, 2'd0, 8'd6, 8'd2);
    check("t6_ready_pend", 32'(cfg_if.cfg_ready), 32'd0);
    rst_n = 1'b0;
    step();
    check("t6_rst_clk_out", 32'(clk_out), 32'd0);
    check("t6_rst_tick", 32'(tick), 32'd0);
    check("t6_rst_err", 32'(cfg_if.cfg_err), 32'd0);
    check("t6_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst_n = 1'b1;
    k     = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      chk_ref(0);
      chk_ref(1);
      chk_ref(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
